// File: rtl/instr_dispatch_queue_pkg.sv
// Shared types for the instruction dispatch queue: instruction type codes and the stored entry layout.
package instr_dispatch_queue_pkg;

  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd0;
  localparam logic [1:0] INSTR_TYPE_RAM        = 2'd1;
  localparam logic [1:0] INSTR_TYPE_LD_ST      = 2'd2;
  localparam logic [1:0] INSTR_TYPE_LOOP       = 2'd3;

  localparam int Q_ADDR_W  = 18;
  localparam int PAYLOAD_W = 14;

  typedef struct packed {
    logic [1:0]           itype;
    logic [PAYLOAD_W-1:0] payload;
    logic [Q_ADDR_W-1:0]  cache_addr;
    logic [Q_ADDR_W-1:0]  main_mem_addr;
    logic [Q_ADDR_W-1:0]  d_cache_addr;
    logic [Q_ADDR_W-1:0]  d_main_mem_addr;
  } queue_entry_t;

  localparam int ENTRY_W = $bits(queue_entry_t);

  // Narrower payloads are zero-extended into the common 14-bit slot.
  function automatic logic [PAYLOAD_W-1:0] pack_payload(input logic [1:0] t,
                                                        input logic [13:0] arith,
                                                        input logic [8:0] ram,
                                                        input logic [9:0] ld_st);
    logic [PAYLOAD_W-1:0] p;
    case (t)
      INSTR_TYPE_ARITHMETIC: p = arith;
      INSTR_TYPE_RAM:        p = {5'd0, ram};
      INSTR_TYPE_LD_ST:      p = {4'd0, ld_st};
      default:               p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/instr_dispatch_queue_if.sv
// Queue-write and dispatch bundle between the control unit, the dispatch queue and the execution front-ends.
interface instr_dispatch_queue_if #(parameter int ADDR_W = 18);
  logic              queue_we;
  logic [1:0]        queue_instr_type;
  logic [13:0]       queue_arith_instr;
  logic [8:0]        queue_ram_instr;
  logic [9:0]        queue_ld_st_instr;
  logic [ADDR_W-1:0] cache_addr;
  logic [ADDR_W-1:0] main_mem_addr;
  logic [ADDR_W-1:0] d_cache_addr;
  logic [ADDR_W-1:0] d_main_mem_addr;
  logic              program_complete;
  logic              queue_full;
  logic              queue_almost_full;
  logic              arith_valid, arith_ready;
  logic [13:0]       arith_instr;
  logic              ram_valid, ram_ready;
  logic [8:0]        ram_instr;
  logic              ld_st_valid, ld_st_ready;
  logic [9:0]        ld_st_instr;
  logic [ADDR_W-1:0] head_cache_addr;
  logic [ADDR_W-1:0] head_main_mem_addr;
  logic [ADDR_W-1:0] head_d_cache_addr;
  logic [ADDR_W-1:0] head_d_main_mem_addr;
  logic              queue_drained;
  logic              queue_error;

  modport master (
    output queue_we, queue_instr_type, queue_arith_instr, queue_ram_instr, queue_ld_st_instr,
           cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr, program_complete,
           arith_ready, ram_ready, ld_st_ready,
    input  queue_full, queue_almost_full, arith_valid, arith_instr, ram_valid, ram_instr,
           ld_st_valid, ld_st_instr, head_cache_addr, head_main_mem_addr, head_d_cache_addr,
           head_d_main_mem_addr, queue_drained, queue_error
  );

  modport slave (
    input  queue_we, queue_instr_type, queue_arith_instr, queue_ram_instr, queue_ld_st_instr,
           cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr, program_complete,
           arith_ready, ram_ready, ld_st_ready,
    output queue_full, queue_almost_full, arith_valid, arith_instr, ram_valid, ram_instr,
           ld_st_valid, ld_st_instr, head_cache_addr, head_main_mem_addr, head_d_cache_addr,
           head_d_main_mem_addr, queue_drained, queue_error
  );
endinterface

// File: rtl/instr_queue_mem.sv
// Entry storage for the dispatch queue: one synchronous write port, one asynchronous read port.
module instr_queue_mem
  import instr_dispatch_queue_pkg::*;
#(
  parameter int LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [LOG_DEPTH-1:0] waddr_i,
  input  queue_entry_t         wdata_i,
  input  logic [LOG_DEPTH-1:0] raddr_i,
  output queue_entry_t         rdata_o
);

  queue_entry_t mem_q [1<<LOG_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_dispatch_queue.sv
// In-order instruction queue feeding the arithmetic, RAM and load/store front-ends.
// Optional occupancy/stall statistics are enabled with `define DISPATCH_QUEUE_STATS_EN.
module instr_dispatch_queue
  import instr_dispatch_queue_pkg::*;
#(
  parameter int LOG_DEPTH    = 4,
  parameter int ADDR_W       = Q_ADDR_W,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_dispatch_queue_if.slave dq
`ifdef DISPATCH_QUEUE_STATS_EN
  ,
  output logic [LOG_DEPTH:0]    stat_high_water,
  output logic [31:0]           stat_stall_cycles
`endif
);

  localparam int CNT_W = LOG_DEPTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(1 << LOG_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'((1 << LOG_DEPTH) - AFULL_MARGIN);

  logic [LOG_DEPTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d, cmpl_q, cmpl_d, drained_q, drained_d;

  queue_entry_t wr_entry, head;
  logic empty, is_loop, arith_v, ram_v, ld_st_v, fire, push;

  assign wr_entry = '{itype:           dq.queue_instr_type,
                      payload:         pack_payload(dq.queue_instr_type, dq.queue_arith_instr,
                                                    dq.queue_ram_instr, dq.queue_ld_st_instr),
                      cache_addr:      dq.cache_addr,
                      main_mem_addr:   dq.main_mem_addr,
                      d_cache_addr:    dq.d_cache_addr,
                      d_main_mem_addr: dq.d_main_mem_addr};

  instr_queue_mem #(.LOG_DEPTH(LOG_DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (tail_q),
    .wdata_i (wr_entry),
    .raddr_i (head_q),
    .rdata_o (head)
  );

  assign empty   = (count_q == '0);
  assign is_loop = (dq.queue_instr_type == INSTR_TYPE_LOOP);
  assign arith_v = !empty && (head.itype == INSTR_TYPE_ARITHMETIC);
  assign ram_v   = !empty && (head.itype == INSTR_TYPE_RAM);
  assign ld_st_v = !empty && (head.itype == INSTR_TYPE_LD_ST);
  assign fire    = (arith_v && dq.arith_ready) || (ram_v && dq.ram_ready) ||
                   (ld_st_v && dq.ld_st_ready);
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign push    = dq.queue_we && !is_loop && ((count_q != DEPTH_C) || fire);

  always_comb begin
    head_d = head_q + LOG_DEPTH'(fire);
    tail_d = tail_q + LOG_DEPTH'(push);
    case ({push, fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    err_d     = err_q || (dq.queue_we && (is_loop || ((count_q == DEPTH_C) && !fire)));
    cmpl_d    = cmpl_q || dq.program_complete;
    drained_d = cmpl_d && (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      cmpl_q    <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      err_q     <= err_d;
      cmpl_q    <= cmpl_d;
      drained_q <= drained_d;
    end
  end

  // Head fields are forced to zero while empty so stale slots never reach the front-ends.
  assign dq.arith_valid          = arith_v;
  assign dq.ram_valid            = ram_v;
  assign dq.ld_st_valid          = ld_st_v;
  assign dq.arith_instr          = empty ? '0 : head.payload;
  assign dq.ram_instr            = empty ? '0 : head.payload[8:0];
  assign dq.ld_st_instr          = empty ? '0 : head.payload[9:0];
  assign dq.head_cache_addr      = empty ? '0 : head.cache_addr;
  assign dq.head_main_mem_addr   = empty ? '0 : head.main_mem_addr;
  assign dq.head_d_cache_addr    = empty ? '0 : head.d_cache_addr;
  assign dq.head_d_main_mem_addr = empty ? '0 : head.d_main_mem_addr;
  assign dq.queue_full           = (count_q == DEPTH_C);
  assign dq.queue_almost_full    = (count_q >= AFULL_C);
  assign dq.queue_drained        = drained_q;
  assign dq.queue_error          = err_q;

`ifdef DISPATCH_QUEUE_STATS_EN
  logic [LOG_DEPTH:0] hw_q;
  logic [31:0]        stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hw_q    <= '0;
      stall_q <= '0;
    end else begin
      if (count_d > hw_q) hw_q <= count_d;
      if (!empty && !fire && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_high_water   = hw_q;
  assign stat_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_instr_dispatch_queue.sv
// Directed bench for instr_dispatch_queue: vector table plus hand-written multi-cycle sequences.
module tb_instr_dispatch_queue;
  import instr_dispatch_queue_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_dispatch_queue_if #(.ADDR_W(18)) dq_if ();

  instr_dispatch_queue #(.LOG_DEPTH(4), .ADDR_W(18), .AFULL_MARGIN(2)) dut (
    .clk   (clk),
    .reset (reset),
    .dq    (dq_if)
  );

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic        we;
    logic [1:0]  t;
    logic [13:0] pl;
    logic [17:0] ca;
    logic [2:0]  rdy;   // {arith, ram, ld_st}
    logic [2:0]  ev;    // {arith, ram, ld_st}
    logic [13:0] ep;
    logic [17:0] eca;
    logic        ee;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    dq_if.queue_we          = 1'b0;
    dq_if.queue_instr_type  = 2'd0;
    dq_if.queue_arith_instr = '0;
    dq_if.queue_ram_instr   = '0;
    dq_if.queue_ld_st_instr = '0;
    dq_if.cache_addr        = '0;
    dq_if.main_mem_addr     = '0;
    dq_if.d_cache_addr      = '0;
    dq_if.d_main_mem_addr   = '0;
    dq_if.program_complete  = 1'b0;
  endtask

  task automatic set_rdy(input logic [2:0] r);
    dq_if.arith_ready = r[2];
    dq_if.ram_ready   = r[1];
    dq_if.ld_st_ready = r[0];
  endtask

  task automatic drive_wr(input logic [1:0] t, input logic [13:0] pl, input logic [17:0] ca);
    dq_if.queue_we          = 1'b1;
    dq_if.queue_instr_type  = t;
    dq_if.queue_arith_instr = pl;
    dq_if.queue_ram_instr   = pl[8:0];
    dq_if.queue_ld_st_instr = pl[9:0];
    dq_if.cache_addr        = ca;
    dq_if.main_mem_addr     = ca + 18'd1;
    dq_if.d_cache_addr      = 18'd2;
    dq_if.d_main_mem_addr   = 18'd3;
  endtask

  task automatic do_reset();
    idle_in();
    set_rdy(3'b000);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  function automatic logic [13:0] head_pay();
    if (dq_if.ram_valid)        return {5'd0, dq_if.ram_instr};
    else if (dq_if.ld_st_valid) return {4'd0, dq_if.ld_st_instr};
    else                        return dq_if.arith_instr;
  endfunction

  function automatic logic [2:0] valids();
    return {dq_if.arith_valid, dq_if.ram_valid, dq_if.ld_st_valid};
  endfunction

  initial begin
    tbl[0] = '{1'b1, INSTR_TYPE_RAM,        14'h020, 18'd3, 3'b000, 3'b010, 14'h020, 18'd3, 1'b0};
    tbl[1] = '{1'b1, INSTR_TYPE_ARITHMETIC, 14'h000, 18'd7, 3'b000, 3'b010, 14'h020, 18'd3, 1'b0};
    for (int i = 2; i <= 6; i++)
      tbl[i] = '{1'b0, INSTR_TYPE_ARITHMETIC, 14'h0, 18'd0, 3'b101, 3'b010, 14'h020, 18'd3, 1'b0};
    tbl[7]  = '{1'b0, INSTR_TYPE_ARITHMETIC, 14'h0,   18'd0, 3'b010, 3'b100, 14'h000, 18'd7, 1'b0};
    tbl[8]  = '{1'b0, INSTR_TYPE_ARITHMETIC, 14'h0,   18'd0, 3'b100, 3'b000, 14'h000, 18'd0, 1'b0};
    tbl[9]  = '{1'b1, INSTR_TYPE_LOOP,       14'h3FF, 18'd9, 3'b000, 3'b000, 14'h000, 18'd0, 1'b1};
    tbl[10] = '{1'b0, INSTR_TYPE_ARITHMETIC, 14'h0,   18'd0, 3'b000, 3'b000, 14'h000, 18'd0, 1'b1};

    // Reset state
    reset = 1'b0;
    idle_in();
    set_rdy(3'b000);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_valids", 32'(valids()), 32'd0);
    chk("rst_full", 32'(dq_if.queue_full), 32'd0);
    chk("rst_afull", 32'(dq_if.queue_almost_full), 32'd0);
    chk("rst_drained", 32'(dq_if.queue_drained), 32'd0);
    chk("rst_error", 32'(dq_if.queue_error), 32'd0);
    chk("rst_head_addr", 32'(dq_if.head_cache_addr), 32'd0);

    // Table: RAM/ARITH ordering, head stall, ignored foreign readies, LOOP rejection
    for (int i = 0; i < 11; i++) begin
      idle_in();
      if (tbl[i].we) drive_wr(tbl[i].t, tbl[i].pl, tbl[i].ca);
      set_rdy(tbl[i].rdy);
      tick();
      chk($sformatf("v%0d_valids", i), 32'(valids()), 32'(tbl[i].ev));
      chk($sformatf("v%0d_payload", i), 32'(head_pay()), 32'(tbl[i].ep));
      chk($sformatf("v%0d_cache_addr", i), 32'(dq_if.head_cache_addr), 32'(tbl[i].eca));
      chk($sformatf("v%0d_error", i), 32'(dq_if.queue_error), 32'(tbl[i].ee));
    end

    // Fill to 16, overflow, then drain in order
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_wr(INSTR_TYPE_ARITHMETIC, 14'(14'h100 + i), 18'(i));
      tick();
      chk($sformatf("fill%0d_afull", i), 32'(dq_if.queue_almost_full), 32'(i + 1 >= 14));
      chk($sformatf("fill%0d_full", i), 32'(dq_if.queue_full), 32'(i == 15));
      chk($sformatf("fill%0d_head", i), 32'(dq_if.arith_instr), 32'h100);
    end
    drive_wr(INSTR_TYPE_ARITHMETIC, 14'h3FFF, 18'd99);
    tick();
    idle_in();
    chk("ovf_full", 32'(dq_if.queue_full), 32'd1);
    chk("ovf_error", 32'(dq_if.queue_error), 32'd1);
    set_rdy(3'b100);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_payload", i), 32'(dq_if.arith_instr), 32'(14'h100 + i));
      chk($sformatf("drain%0d_addr", i), 32'(dq_if.head_cache_addr), 32'(i));
      tick();
    end
    chk("drain_empty_valid", 32'(dq_if.arith_valid), 32'd0);
    chk("drain_empty_full", 32'(dq_if.queue_full), 32'd0);

    // Full queue: write coincident with a load/store dispatch
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_wr(INSTR_TYPE_LD_ST, 14'(14'h40 + i), 18'(i));
      tick();
    end
    chk("fs_full_before", 32'(dq_if.queue_full), 32'd1);
    drive_wr(INSTR_TYPE_LD_ST, 14'h3AA, 18'd50);
    set_rdy(3'b001);
    tick();
    idle_in();
    chk("fs_full_after", 32'(dq_if.queue_full), 32'd1);
    chk("fs_error", 32'(dq_if.queue_error), 32'd0);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("fs_drain%0d", i), 32'(dq_if.ld_st_instr), 32'(14'h40 + i));
      tick();
    end
    chk("fs_last_payload", 32'(dq_if.ld_st_instr), 32'h3AA);
    chk("fs_last_addr", 32'(dq_if.head_cache_addr), 32'd50);
    tick();
    chk("fs_empty", 32'(dq_if.ld_st_valid), 32'd0);

    // Completion latch and drain reporting
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive_wr(INSTR_TYPE_RAM, 14'(i), 18'(i));
      tick();
    end
    idle_in();
    dq_if.program_complete = 1'b1;
    tick();
    dq_if.program_complete = 1'b0;
    chk("cmp_drained_q3", 32'(dq_if.queue_drained), 32'd0);
    set_rdy(3'b010);
    tick();
    chk("cmp_drained_fire1", 32'(dq_if.queue_drained), 32'd0);
    tick();
    chk("cmp_drained_fire2", 32'(dq_if.queue_drained), 32'd0);
    tick();
    chk("cmp_drained_fire3", 32'(dq_if.queue_drained), 32'd1);
    drive_wr(INSTR_TYPE_RAM, 14'h5, 18'd5);
    tick();
    idle_in();
    chk("cmp_late_drained", 32'(dq_if.queue_drained), 32'd0);
    chk("cmp_late_valid", 32'(dq_if.ram_valid), 32'd1);
    tick();
    chk("cmp_late_redrained", 32'(dq_if.queue_drained), 32'd1);

    // Asynchronous reset in the middle of a drain
    set_rdy(3'b000);
    drive_wr(INSTR_TYPE_RAM, 14'h6, 18'd6);
    tick();
    tick();
    idle_in();
    chk("mid_valid_pre", 32'(dq_if.ram_valid), 32'd1);
    set_rdy(3'b010);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(dq_if.ram_valid), 32'd0);
    chk("mid_rst_drained", 32'(dq_if.queue_drained), 32'd0);
    chk("mid_rst_afull", 32'(dq_if.queue_almost_full), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_valid", 32'(dq_if.ram_valid), 32'd0);
    chk("post_rst_drained", 32'(dq_if.queue_drained), 32'd0);
    chk("post_rst_error", 32'(dq_if.queue_error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
